// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_I    = 2'd1,
    ARB_D    = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational tie-break between fetch and data requesters.
// Round-robin when MEM_ARBITER_RR_EN is defined, otherwise the data port wins ties.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t last_owner_i,
  output owner_t grant_o
);

  always_comb begin
    grant_o = OWN_I;
    if (i_req && d_req) begin
`ifdef MEM_ARBITER_RR_EN
      grant_o = (last_owner_i == OWN_I) ? OWN_D : OWN_I;
`else
      grant_o = OWN_D;
`endif
    end else if (d_req) begin
      grant_o = OWN_D;
    end
  end

`ifndef MEM_ARBITER_RR_EN
  logic unused_last;
  assign unused_last = (last_owner_i == OWN_D);
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-port memory.
// Define MEM_ARBITER_RR_EN for round-robin tie-breaking instead of data-port priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_ready,
  output logic [DATA_W-1:0]     i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W/8-1:0]   d_wmask,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_ready,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W/8-1:0]   m_wmask,
  output logic [DATA_W-1:0]     m_wdata,
  input  logic                  m_ack,
  input  logic [DATA_W-1:0]     m_rdata
);

  localparam int MASK_W = DATA_W / 8;

  arb_state_t          state_q;
  logic                m_req_q;
  logic                m_we_q;
  logic [ADDR_W-1:0]   m_addr_q;
  logic [MASK_W-1:0]   m_wmask_q;
  logic [DATA_W-1:0]   m_wdata_q;
  owner_t              last_owner;
  owner_t              grant;

`ifdef MEM_ARBITER_RR_EN
  owner_t last_q;
  assign last_owner = last_q;
`else
  assign last_owner = OWN_I;
`endif

  arb_pick u_pick (
    .i_req        (i_req),
    .d_req        (d_req),
    .last_owner_i (last_owner),
    .grant_o      (grant)
  );

  // Memory-side signals are registered at grant and cleared on ack, so they stay stable while waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wmask_q <= '0;
      m_wdata_q <= '0;
`ifdef MEM_ARBITER_RR_EN
      last_q    <= OWN_I;
`endif
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (i_req || d_req) begin
            m_req_q <= 1'b1;
`ifdef MEM_ARBITER_RR_EN
            last_q  <= grant;
`endif
            if (grant == OWN_D) begin
              state_q   <= ARB_D;
              m_we_q    <= d_we;
              m_addr_q  <= d_addr;
              m_wmask_q <= d_we ? d_wmask : '0;
              m_wdata_q <= d_wdata;
            end else begin
              state_q   <= ARB_I;
              m_we_q    <= 1'b0;
              m_addr_q  <= i_addr;
              m_wmask_q <= '0;
            end
          end
        end
        ARB_I, ARB_D: begin
          if (m_ack) begin
            state_q   <= ARB_IDLE;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_wmask_q <= '0;
          end
        end
        default: begin
          state_q   <= ARB_IDLE;
          m_req_q   <= 1'b0;
          m_we_q    <= 1'b0;
          m_wmask_q <= '0;
        end
      endcase
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wmask = m_wmask_q;
  assign m_wdata = m_wdata_q;

  // An ack arriving in the reset cycle must not complete the abandoned transaction.
  assign i_ready = (state_q == ARB_I) && m_ack && !rst;
  assign d_ready = (state_q == ARB_D) && m_ack && !rst;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: randomized requests against a transaction-level model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          iReq, iReady;
  logic [AW-1:0] iAddr;
  logic [DW-1:0] iRdata;
  logic          dReq, dWe, dReady;
  logic [AW-1:0] dAddr;
  logic [MW-1:0] dWmask;
  logic [DW-1:0] dWdata, dRdata;
  logic          mReq, mWe, mAck;
  logic [AW-1:0] mAddr;
  logic [MW-1:0] mWmask;
  logic [DW-1:0] mWdata, mRdata;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(iReq), .i_addr(iAddr), .i_ready(iReady), .i_rdata(iRdata),
    .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wmask(dWmask), .d_wdata(dWdata),
    .d_ready(dReady), .d_rdata(dRdata),
    .m_req(mReq), .m_we(mWe), .m_addr(mAddr), .m_wmask(mWmask), .m_wdata(mWdata),
    .m_ack(mAck), .m_rdata(mRdata)
  );

  typedef struct {
    owner_t        owner;
    logic [AW-1:0] addr;
    logic          we;
    logic [MW-1:0] wmask;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t   expQ[$];
  owner_t grantLog[$];
  int     checks = 0;
  int     errors = 0;
  bit     pendI = 1'b0;
  bit     pendD = 1'b0;
  owner_t modelLast = OWN_I;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Arbitration rule from the port's point of view: a lone request wins, a tie goes by mode.
  function automatic owner_t modelPick();
    if (pendI && pendD) begin
`ifdef MEM_ARBITER_RR_EN
      return (modelLast == OWN_D) ? OWN_I : OWN_D;
`else
      return OWN_D;
`endif
    end
    return pendD ? OWN_D : OWN_I;
  endfunction

  task automatic requestI(input logic [AW-1:0] addr);
    pendI = 1'b1;
    iAddr = addr;
  endtask

  task automatic requestD(input logic we, input logic [AW-1:0] addr, input logic [MW-1:0] mask,
                          input logic [DW-1:0] data);
    pendD  = 1'b1;
    dWe    = we;
    dAddr  = addr;
    dWmask = mask;
    dWdata = data;
  endtask

  task automatic doReset();
    rst = 1'b1; mAck = 1'b0; iReq = 1'b0; dReq = 1'b0;
    pendI = 1'b0; pendD = 1'b0; modelLast = OWN_I;
    expQ.delete();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset m_req", mReq, 1'b0);
    checkOutput("reset m_we/m_wmask", {mWe, mWmask}, '0);
    checkOutput("reset m_addr/m_wdata", {mAddr, mWdata}, '0);
    checkOutput("reset readies", {iReady, dReady}, 2'b00);
    rst = 1'b0;
  endtask

  // One arbitration round: issue pending requests, answer the granted access after waitCycles.
  task automatic applyStimulus(input int waitCycles, input bit dropWinner, input logic [DW-1:0] rdata);
    exp_t   e;
    owner_t w;
    iReq = pendI;
    dReq = pendD;
    if (!pendI && !pendD) begin
      @(posedge clk); #1;
      checkOutput("idle without request", mReq, 1'b0);
      return;
    end
    w = modelPick();
    modelLast = w;
    e.owner = w;
    e.rdata = rdata;
    if (w == OWN_I) begin
      e.addr = iAddr; e.we = 1'b0; e.wmask = '0; e.wdata = '0;
    end else begin
      e.addr = dAddr; e.we = dWe; e.wmask = dWe ? dWmask : '0; e.wdata = dWdata;
    end
    expQ.push_back(e);
    @(posedge clk); #1;
    checkOutput("grant latency", mReq, 1'b1);
    if (dropWinner) begin
      if (w == OWN_I) iReq = 1'b0;
      else dReq = 1'b0;
    end
    for (int k = 0; k < waitCycles; k++) begin
      @(posedge clk); #1;
      checkOutput("m_req held while waiting", mReq, 1'b1);
    end
    mRdata = rdata;
    mAck = 1'b1;
    @(posedge clk); #1;
    mAck = 1'b0;
    mRdata = $urandom;
    if (w == OWN_I) pendI = 1'b0;
    else pendD = 1'b0;
    iReq = pendI;
    dReq = pendD;
    checkOutput("scoreboard drained", expQ.size(), 0);
    if (expQ.size() != 0) expQ.delete();
    checkOutput("idle cycle after ack", mReq, 1'b0);
  endtask

  // Monitor: protocol checks every cycle, scoreboard pop on each ready pulse.
  initial begin : monitor
    logic                inTxn;
    logic [AW+MW+DW:0]   capBus;
    exp_t                e;
    inTxn = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !mReq) inTxn = 1'b0;
      if (!rst && mReq) begin
        if (!inTxn) begin
          capBus = {mAddr, mWe, mWmask, mWdata};
          inTxn  = 1'b1;
        end else begin
          checkOutput("m_* stable", {mAddr, mWe, mWmask, mWdata}, capBus);
        end
      end
      if (!rst && !mReq) checkOutput("idle m_we/m_wmask", {mWe, mWmask}, '0);
      if (iReady || dReady) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected ready actual=%b%b required=00", iReady, dReady);
        end else begin
          e = expQ.pop_front();
          grantLog.push_back(iReady ? OWN_I : OWN_D);
          checkOutput("ready owner", {iReady, dReady}, (e.owner == OWN_I) ? 2'b10 : 2'b01);
          checkOutput("m_addr", mAddr, e.addr);
          checkOutput("m_we/m_wmask", {mWe, mWmask}, {e.we, e.wmask});
          if (e.owner == OWN_D) checkOutput("m_wdata", mWdata, e.wdata);
          checkOutput("rdata", (e.owner == OWN_I) ? iRdata : dRdata, e.rdata);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog timeout actual=running required=done");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stimulus
    owner_t expTie[4];
`ifdef MEM_ARBITER_RR_EN
    expTie = '{OWN_D, OWN_I, OWN_D, OWN_I};
`else
    expTie = '{OWN_D, OWN_D, OWN_D, OWN_D};
`endif
    iReq = 1'b0; iAddr = '0; dReq = 1'b0; dWe = 1'b0; dAddr = '0; dWmask = '0; dWdata = '0;
    mAck = 1'b0; mRdata = '0;
    doReset();

    $display("[TB] lone fetch");
    requestI(32'h100);
    applyStimulus(0, 1'b0, 32'h0000_0013);

    $display("[TB] data write with wait states");
    requestD(1'b1, 32'h2004, 4'h3, 32'hDEAD_BEEF);
    applyStimulus(2, 1'b0, $urandom);

    $display("[TB] stray ack while idle, then fetch with dropped request");
    for (int k = 0; k < 3; k++) begin
      mAck = 1'b1;
      mRdata = $urandom;
      @(posedge clk); #1;
      checkOutput("stray ack m_req", mReq, 1'b0);
    end
    mAck = 1'b0;
    requestI($urandom);
    applyStimulus(1, 1'b1, $urandom);

    $display("[TB] reset mid-transaction");
    requestD(1'b0, $urandom, 4'hF, $urandom);
    dReq = 1'b1;
    @(posedge clk); #1;
    checkOutput("abandoned txn m_req", mReq, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    mAck = 1'b1;
    @(negedge clk);
    checkOutput("no ready in reset cycle", {iReady, dReady}, 2'b00);
    @(posedge clk); #1;
    checkOutput("m_req after reset", mReq, 1'b0);
    rst = 1'b0; mAck = 1'b0; dReq = 1'b0; iReq = 1'b0;
    pendI = 1'b0; pendD = 1'b0; modelLast = OWN_I;
    @(posedge clk); #1;
    checkOutput("idle after reset", mReq, 1'b0);

    doReset();
    $display("[TB] persistent tie, last owner %s", modelLast.name());
    grantLog.delete();
    for (int k = 0; k < 4; k++) begin
      if (!pendI) requestI($urandom);
      if (!pendD) requestD(1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom);
      applyStimulus($urandom_range(0, 2), 1'b0, $urandom);
    end
    checkOutput("tie grant count", grantLog.size(), 4);
    if (grantLog.size() >= 4)
      for (int k = 0; k < 4; k++) checkOutput($sformatf("tie grant %0d", k), grantLog[k], expTie[k]);

    $display("[TB] random traffic");
    for (int r = 0; r < 120; r++) begin
      if (!pendI && $urandom_range(0, 1) == 1) requestI($urandom);
      if (!pendD && $urandom_range(0, 1) == 1)
        requestD(1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom);
      applyStimulus($urandom_range(0, 3), ($urandom_range(0, 3) == 0), $urandom);
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byte mask width is DATA_W/8.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports i_req in 1, i_addr in ADDR_W, i_ready out 1, i_rdata out DATA_W: instruction-fetch port, read-only.
REQ-006 SHALL have ports d_req in 1, d_we in 1, d_addr in ADDR_W, d_wmask in DATA_W/8, d_wdata in DATA_W, d_ready out 1, d_rdata out DATA_W: data port.
REQ-007 SHALL have ports m_req out 1, m_we out 1, m_addr out ADDR_W, m_wmask out DATA_W/8, m_wdata out DATA_W, m_ack in 1, m_rdata in DATA_W: shared single-port memory.

Function
REQ-008 SHALL implement FSM states ARB_IDLE, ARB_I, ARB_D.
REQ-009 ARB_IDLE: if any request is pending, grant one requester, register its addr/we/wmask/wdata into m_*, and enter ARB_I or ARB_D next cycle; otherwise stay.
REQ-010 Fetch grant SHALL drive m_we=0 and m_wmask=0; data read (d_we=0) SHALL drive m_wmask=0.
REQ-011 m_req SHALL be 1 exactly while state is ARB_I or ARB_D; m_* SHALL stay stable until m_ack.
REQ-012 In ARB_I/ARB_D with m_ack=1: owner's ready=1 combinationally in that cycle, owner's rdata=m_rdata, next state ARB_IDLE.
REQ-013 Non-owner ready SHALL be 0 at all times; i_rdata/d_rdata are don't-care while the corresponding ready is 0.
REQ-014 Minimum latency: req sampled in cycle N, m_req in N+1, ready in N+1 if m_ack in N+1; every transaction includes one ARB_IDLE cycle before the next grant.
REQ-015 Requesters SHALL hold req and payload until ready; if req drops mid-transaction, the transaction still completes and ready still pulses.
REQ-016 m_ack while in ARB_IDLE SHALL be ignored.
REQ-017 When m_req=0, m_we and m_wmask SHALL be 0; m_addr/m_wdata hold their last value.
REQ-018 Memory wait is unbounded; no timeout.

Reset
REQ-019 rst=1 SHALL force ARB_IDLE next cycle, with m_req=0, m_we=0, m_wmask=0, m_addr=0, m_wdata=0, i_ready=0, d_ready=0.
REQ-020 rst during ARB_I/ARB_D SHALL abandon the transaction without a ready pulse; an m_ack in the reset cycle is ignored.
REQ-021 Round-robin last-owner register (when compiled in) SHALL reset to I, so the data port wins the first tie.

Configuration
REQ-022 Macro MEM_ARBITER_RR_EN: defined -> a simultaneous i_req/d_req tie goes to the port not granted last; last-owner is updated on every grant.
REQ-023 Without MEM_ARBITER_RR_EN: fixed priority, d_req always wins a tie; no last-owner register exists.
REQ-024 In both modes, a single pending request SHALL be granted immediately.

Structure
REQ-025 Package mem_arb_pkg SHALL hold the arb_state_t enum (ARB_IDLE, ARB_I, ARB_D), the owner_t enum (OWN_I, OWN_D) and the default width constants.
REQ-026 Tie-break logic SHALL be a sub-module arb_pick (inputs i_req, d_req, last owner; output grant owner), purely combinational.

Verification
REQ-027 Lone fetch: i_req=1, i_addr=0x100, m_ack in the first m_req cycle with m_rdata=0x00000013 -> m_addr=0x100, m_we=0, i_ready=1 for one cycle, i_rdata=0x13, d_ready=0.
REQ-028 Data write with 3-cycle wait: d_we=1, d_addr=0x2004, d_wmask=0x3, d_wdata=0xDEADBEEF -> m_req high for 3 cycles with stable m_*, d_ready on the 3rd cycle, then one ARB_IDLE cycle.
REQ-029 Persistent tie, i_req=d_req=1 for 4 transactions -> fixed build grants D,D,D,D; MEM_ARBITER_RR_EN build grants D,I,D,I.
REQ-030 Reset mid-transaction: rst in the 2nd m_req cycle with m_ack=1 -> no ready pulse, m_req=0 next cycle, state ARB_IDLE.
REQ-031 Stray m_ack=1 in ARB_IDLE with no requests -> no ready and no state change; i_req dropped mid-transaction -> i_ready still pulses on ack.
